// File: rtl/ifetch_pkg.sv
// Shared widths, reset PC and FSM state encoding for the instruction fetch sequencer.
package ifetch_pkg;

   localparam int unsigned DEF_ADDR_W   = 8;
   localparam int unsigned DEF_INSTR_W  = 32;
   localparam int unsigned DEF_RESET_PC = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/ifetch_fifo2.sv
// Two-entry prefetch FIFO holding {instruction word, fetch address} pairs.
// Flush has priority over push and pop; push into a full FIFO is accepted only
// alongside a pop.
module ifetch_fifo2
   import ifetch_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned INSTR_W = DEF_INSTR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [0:INSTR_W-1] push_data,
   input  logic [0:ADDR_W-1]  push_pc,
   output logic [1:0]         count,
   output logic [0:INSTR_W-1] head_data,
   output logic [0:ADDR_W-1]  head_pc
);

   logic [0:INSTR_W-1] data_q [2];
   logic [0:ADDR_W-1]  pc_q   [2];
   logic               rd_ptr_q;
   logic               wr_ptr_q;
   logic [1:0]         count_q;
   logic [1:0]         count_d;
   logic               pop_ok;
   logic               push_ok;

   // Qualify requests against occupancy so the pointers can never over/underrun.
   always_comb begin
      pop_ok  = pop && (count_q != 2'd0);
      push_ok = push && ((count_q != 2'd2) || pop_ok);
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 2'd1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 2'd1;
      end
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush) begin
         // Head keeps pointing at the last presented entry so instr/instr_pc hold.
         wr_ptr_q <= rd_ptr_q;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            data_q[wr_ptr_q] <= push_data;
            pc_q[wr_ptr_q]   <= push_pc;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   // Head presentation.
   always_comb begin
      count     = count_q;
      head_data = data_q[rd_ptr_q];
      head_pc   = pc_q[rd_ptr_q];
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs the IDLE/RUN/HALTED control FSM,
// fetches from a combinational-read instruction memory into a 2-entry prefetch
// buffer and hands words to decode with a valid/ready handshake. Redirect flushes
// the buffer and reloads the PC from any state.
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned INSTR_W  = DEF_INSTR_W,
   parameter int unsigned RESET_PC = DEF_RESET_PC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               halt,
   input  logic               redirect,
   input  logic [0:ADDR_W-1]  redirect_pc,
   output logic [0:ADDR_W-1]  imem_addr,
   input  logic [0:INSTR_W-1] imem_data,
   output logic [0:INSTR_W-1] instr,
   output logic [0:ADDR_W-1]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic               busy
);

   state_t            state_q;
   state_t            state_d;
   logic [0:ADDR_W-1] pc_q;
   logic [0:ADDR_W-1] pc_d;
   logic [1:0]        count;
   logic              pop;
   logic              fetch;

   ifetch_fifo2 #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fetch),
      .pop       (pop),
      .flush     (redirect),
      .push_data (imem_data),
      .push_pc   (pc_q),
      .count     (count),
      .head_data (instr),
      .head_pc   (instr_pc)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; redirect freezes the state, halt beats start in HALTED.
   always_comb begin
      state_d = state_q;
      if (!redirect) begin
         unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (halt) state_d = HALTED;
            HALTED:  if (start && !halt) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // Handshake, fetch qualification and next PC.
   always_comb begin
      instr_valid = (count != 2'd0);
      pop         = instr_valid && instr_ready;
      fetch       = (state_q == RUN) && !halt && !redirect && ((count != 2'd2) || pop);
      pc_d        = pc_q;
      if (redirect) begin
         pc_d = redirect_pc;
      end else if (fetch) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   // Program counter; wraps naturally at 2^ADDR_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= ADDR_W'(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   // Status outputs.
   always_comb begin
      imem_addr = pc_q;
      busy      = !((state_q == IDLE) || ((state_q == HALTED) && (count == 2'd0)));
   end

endmodule
